// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one 8-bit SDRAM transaction port between the boot
// loader, the video fetch and the CPU. Fixed priority boot > vid > cpu, a CPU
// starvation guard, and a watchdog that aborts transactions the controller never acks.
module sdram_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 31,
  parameter logic [6:0]  VID_PAGE   = 7'h02
) (
  input  logic        clk_sys,
  input  logic        RESET_n,
  input  logic        boot_req,
  input  logic [22:0] boot_addr,
  input  logic [1:0]  boot_bank,
  input  logic [7:0]  boot_din,
  output logic        boot_ack,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_dout,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [22:0] cpu_addr,
  input  logic [1:0]  cpu_bank,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic [7:0]  cpu_dout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_bank,
  output logic [7:0]  mem_din,
  input  logic        mem_ack,
  input  logic [7:0]  mem_dout,
  output logic        err
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
  typedef enum logic [1:0] {W_NONE, W_BOOT, W_VID, W_CPU} owner_t;

  state_t        state, state_d;
  owner_t        owner, owner_d, grant;
  logic [SW-1:0] starve, starve_d;
  logic [WW-1:0] wdog, wdog_d;
  logic          starve_full;
  logic          finish;
  logic [7:0]    rd_data;

  logic          mem_req_d, mem_we_d;
  logic [22:0]   mem_addr_d;
  logic [1:0]    mem_bank_d;
  logic [7:0]    mem_din_d;
  logic          boot_ack_d, vid_ack_d, cpu_ack_d;
  logic [7:0]    vid_dout_d, cpu_dout_d;
  logic          err_d;

  assign starve_full = (starve == SW'(STARVE_MAX));

  // Next-state, grant selection, watchdog and completion handling
  always_comb begin
    state_d    = state;
    owner_d    = owner;
    starve_d   = starve;
    wdog_d     = wdog;
    mem_req_d  = mem_req;
    mem_we_d   = mem_we;
    mem_addr_d = mem_addr;
    mem_bank_d = mem_bank;
    mem_din_d  = mem_din;
    boot_ack_d = 1'b0;
    vid_ack_d  = 1'b0;
    cpu_ack_d  = 1'b0;
    vid_dout_d = vid_dout;
    cpu_dout_d = cpu_dout;
    err_d      = err;
    grant      = W_NONE;
    finish     = 1'b0;
    rd_data    = mem_ack ? mem_dout : 8'hFF;

    case (state)
      S_IDLE: begin
        if (boot_req)                    grant = W_BOOT;
        else if (cpu_req && starve_full) grant = W_CPU;
        else if (vid_req)                grant = W_VID;
        else if (cpu_req)                grant = W_CPU;

        if (grant != W_NONE) begin
          state_d   = S_ISSUE;
          owner_d   = grant;
          wdog_d    = '0;
          mem_req_d = 1'b1;
        end

        case (grant)
          W_BOOT: begin
            mem_addr_d = boot_addr;
            mem_bank_d = boot_bank;
            mem_din_d  = boot_din;
            mem_we_d   = 1'b1;
          end
          W_VID: begin
            mem_addr_d = {VID_PAGE, vid_addr};
            mem_bank_d = 2'b00;
            mem_din_d  = 8'h00;
            mem_we_d   = 1'b0;
          end
          W_CPU: begin
            mem_addr_d = cpu_addr;
            mem_bank_d = cpu_bank;
            mem_din_d  = cpu_din;
            mem_we_d   = cpu_we;
          end
          default: ;
        endcase

        // A boot grant with the CPU waiting leaves the starvation count alone
        if (grant == W_VID && cpu_req) begin
          if (!starve_full) starve_d = starve + SW'(1);
        end else if (grant == W_CPU || (grant != W_NONE && !cpu_req)) begin
          starve_d = '0;
        end
      end

      S_ISSUE: begin
        // mem_ack on the final watchdog cycle still counts as a normal completion
        if (mem_ack) begin
          finish = 1'b1;
        end else if (wdog == WW'(TIMEOUT - 1)) begin
          finish = 1'b1;
          err_d  = 1'b1;
        end else begin
          wdog_d = wdog + WW'(1);
        end

        if (finish) begin
          mem_req_d = 1'b0;
          state_d   = S_DONE;
          case (owner)
            W_BOOT: boot_ack_d = 1'b1;
            W_VID: begin
              vid_ack_d  = 1'b1;
              vid_dout_d = rd_data;
            end
            W_CPU: begin
              cpu_ack_d = 1'b1;
              if (!mem_we) cpu_dout_d = rd_data;
            end
            default: ;
          endcase
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      state    <= S_IDLE;
      owner    <= W_NONE;
      starve   <= '0;
      wdog     <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_bank <= '0;
      mem_din  <= '0;
      boot_ack <= 1'b0;
      vid_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      vid_dout <= 8'hFF;
      cpu_dout <= 8'hFF;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      owner    <= owner_d;
      starve   <= starve_d;
      wdog     <= wdog_d;
      mem_req  <= mem_req_d;
      mem_we   <= mem_we_d;
      mem_addr <= mem_addr_d;
      mem_bank <= mem_bank_d;
      mem_din  <= mem_din_d;
      boot_ack <= boot_ack_d;
      vid_ack  <= vid_ack_d;
      cpu_ack  <= cpu_ack_d;
      vid_dout <= vid_dout_d;
      cpu_dout <= cpu_dout_d;
      err      <= err_d;
    end
  end

endmodule
